fifo_rd_ctrl: RTL and testbench

Read-side controller of the PCS TX asynchronous FIFO, running in the read clock domain.
- Consumes the write pointer after the two-flop synchroniser (Gray, ADDRSIZE+1 bits).
- Generates the Gray read pointer for the read-to-write synchroniser, plus the RAM read address/enable and empty, almost-empty and level status.
- Presents data to the downstream PCS stage through a first-word-fall-through valid/ready interface with a 2-entry output buffer, so throughput is bubble-free.

---
 rtl/fifo_pkg.sv | 39 +++
 rtl/fifo_rd_ctrl_if.sv | 19 +
 rtl/fifo_rd_obuf.sv | 88 ++++++++
 rtl/fifo_rd_ctrl.sv | 99 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the PCS TX asynchronous FIFO controllers.
//   ADDRSIZE_DEF / DATA_W_DEF : default address width and RAM word width
//   obuf_state_e              : occupancy states of the read-side output buffer
//   bin2gray / gray2bin       : pointer code conversions. They work on a 32-bit
//                               container: a narrower pointer is zero-extended
//                               on the way in and truncated on the way out, and
//                               both conversions give the same low bits as a
//                               native-width conversion would.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 7;
    localparam int DATA_W_DEF   = 66;
    localparam int GRAY_MAX_W   = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

    typedef enum logic [1:0] {
        OBUF_EMPTY = 2'd0,
        OBUF_ONE   = 2'd1,
        OBUF_TWO   = 2'd2
    } obuf_state_e;

    function automatic gray_vec_t bin2gray(input gray_vec_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gray_vec_t gray2bin(input gray_vec_t g);
        gray_vec_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_if
// First-word-fall-through valid/ready stream from the FIFO read controller to
// the downstream PCS stage.
//   rdata  : head-of-buffer word
//   rvalid : rdata holds a word
//   rready : downstream accepts; a word moves when rvalid & rready
// master = FIFO read controller, slave = downstream consumer.
// -----------------------------------------------------------------------------
interface fifo_rd_ctrl_if #(
    parameter int DATA_W = fifo_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    modport master (output rdata, output rvalid, input rready);
    modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/fifo_rd_obuf.sv
// -----------------------------------------------------------------------------
// fifo_rd_obuf
// Two-entry output buffer behind the RAM read port. The head entry drives the
// stream directly; the tail entry only holds a word while the head is stalled.
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   cap_i        : RAM word on cap_data_i is to be appended this edge
//   cap_data_i   : RAM read data
//   pop_i        : head is consumed this edge (rvalid & rready)
//   occ_o        : number of words held, 0..2
//   head_o       : head word (rdata)
//   valid_o      : head word is valid (rvalid)
// -----------------------------------------------------------------------------
module fifo_rd_obuf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] cap_data_i,
    input  logic              pop_i,
    output logic [1:0]        occ_o,
    output logic [DATA_W-1:0] head_o,
    output logic              valid_o
);

    obuf_state_e       state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= OBUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // A capture arriving together with a pop lands behind any word still
    // queued, so delivery order always matches RAM read order.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            OBUF_EMPTY: begin
                if (cap_i) begin
                    head_d  = cap_data_i;
                    state_d = OBUF_ONE;
                end
            end
            OBUF_ONE: begin
                case ({pop_i, cap_i})
                    2'b11:   head_d = cap_data_i;
                    2'b10:   state_d = OBUF_EMPTY;
                    2'b01: begin
                        tail_d  = cap_data_i;
                        state_d = OBUF_TWO;
                    end
                    default: ;
                endcase
            end
            OBUF_TWO: begin
                // No capture can arrive here without a pop: the read enable
                // only issues when a slot will be free.
                if (pop_i) begin
                    head_d = tail_q;
                    if (cap_i) begin
                        tail_d = cap_data_i;
                    end else begin
                        state_d = OBUF_ONE;
                    end
                end
            end
            default: state_d = OBUF_EMPTY;
        endcase
    end

    assign occ_o   = 2'(state_q);
    assign valid_o = (state_q != OBUF_EMPTY);
    assign head_o  = head_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of the PCS TX asynchronous FIFO (read clock domain).
//   rclk, rrst_n  : read clock, asynchronous active-low reset
//   rq2_wptr      : synchronised Gray write pointer (ADDRSIZE+1 bits)
//   rptr          : registered Gray read pointer, to the r2w synchroniser
//   raddr, rden   : RAM read address / enable; RAM returns data next cycle
//   rmem_data     : RAM read data
//   rd_if         : FWFT valid/ready stream to the downstream PCS stage
//   rempty        : no unread words left in RAM (buffered words not counted)
//   ralmost_empty : rlevel <= AE_THRESH
//   rlevel        : words in RAM not yet read
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int AE_THRESH = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rden,
    input  logic [DATA_W-1:0]   rmem_data,
    fifo_rd_ctrl_if.master      rd_if,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int PTR_W = ADDRSIZE + 1;

    logic [PTR_W-1:0] rbin_q, rbin_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] rlevel_q, rlevel_d;
    logic [PTR_W-1:0] wbin_s;
    logic             rempty_q, rempty_d;
    logic             rae_q, rae_d;
    logic             inflight_q;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       pending;

    // Words that will sit in the output buffer after this edge if no new read
    // is issued; a read is only started when a slot is guaranteed free.
    assign pop     = rd_if.rvalid & rd_if.rready;
    assign pending = {2'b00, inflight_q} + {1'b0, occ} - {2'b00, pop};
    assign rden    = !rempty_q && (pending < 3'd2);
    assign raddr   = rbin_q[ADDRSIZE-1:0];

    assign rbin_d   = rbin_q + PTR_W'(rden);
    assign rptr_d   = PTR_W'(bin2gray(gray_vec_t'(rbin_d)));
    assign wbin_s   = PTR_W'(gray2bin(gray_vec_t'(rq2_wptr)));
    // Modulo subtraction; the wrap bit keeps full (2^ADDRSIZE) distinct from 0.
    assign rlevel_d = wbin_s - rbin_d;
    assign rae_d    = (rlevel_d <= PTR_W'(AE_THRESH));
    assign rempty_d = (rptr_d == rq2_wptr);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            rempty_q   <= 1'b1;
            rae_q      <= 1'b1;
            rlevel_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            rempty_q   <= rempty_d;
            rae_q      <= rae_d;
            rlevel_q   <= rlevel_d;
            inflight_q <= rden;
        end
    end

    // inflight_q marks that rmem_data carries the word addressed last cycle.
    fifo_rd_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .cap_i      (inflight_q),
        .cap_data_i (rmem_data),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_o     (rd_if.rdata),
        .valid_o    (rd_if.rvalid)
    );

    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = rae_q;
    assign rlevel        = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    localparam int AS    = 7;
    localparam int PW    = AS + 1;
    localparam int DW    = 66;
    localparam int DEPTH = 128;

    logic          rclk   = 1'b0;
    logic          rrst_n = 1'b0;
    logic [PW-1:0] rq2_wptr = '0;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rlevel;
    logic [AS-1:0] raddr;
    logic          rden;
    logic          rempty;
    logic          ralmost_empty;
    logic [DW-1:0] rmem_data;
    logic [DW-1:0] mem [DEPTH];

    fifo_rd_ctrl_if #(.DATA_W(DW)) rif ();

    fifo_rd_ctrl #(
        .ADDRSIZE  (AS),
        .DATA_W    (DW),
        .AE_THRESH (4)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rq2_wptr      (rq2_wptr),
        .rptr          (rptr),
        .raddr         (raddr),
        .rden          (rden),
        .rmem_data     (rmem_data),
        .rd_if         (rif.master),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel)
    );

    always #5 rclk = ~rclk;

    // RAM with one-cycle registered read
    always @(posedge rclk) begin
        if (rden) rmem_data <= mem[raddr];
    end

    typedef struct {
        bit rst;
        int wptr;
        bit rdy;
        bit rden;
        int raddr;
        bit rvalid;
        int didx;
        bit rempty;
        int rlevel;
        bit ae;
    } vec_t;

    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    // Reference model: absolute word counts plus a queue of buffered word indices
    int wabs, rd_m, level_m, infl_idx;
    bit empty_m, ae_m, inflight_m;
    int q[$];
    int pops, rden_cnt;
    int raddr_log[$];

    function automatic logic [DW-1:0] word(input int k);
        logic [31:0] u;
        u = k;
        return {u[1:0], 32'hC0DE0000 ^ u, u * 32'h9E3779B9};
    endfunction

    function automatic logic [PW-1:0] gray8(input int b);
        logic [PW-1:0] x;
        x = b[PW-1:0];
        return x ^ (x >> 1);
    endfunction

    function automatic void add(input bit rst, input int wp, input bit rdy, input bit rd,
                                input int ra, input bit rv, input int di, input bit re,
                                input int rl, input bit ae);
        vec_t v;
        v.rst = rst; v.wptr = wp; v.rdy = rdy; v.rden = rd; v.raddr = ra;
        v.rvalid = rv; v.didx = di; v.rempty = re; v.rlevel = rl; v.ae = ae;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rd_m = 0; level_m = 0; infl_idx = 0;
        empty_m = 1'b1; ae_m = 1'b1; inflight_m = 1'b0;
        q.delete();
    endtask

    // Called at a negedge; leaves at a negedge.
    task automatic do_reset();
        rrst_n = 1'b0;
        rif.rready = 1'b0;
        wabs = 0;
        rq2_wptr = '0;
        model_reset();
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    // Publish writes up to absolute count w: fill RAM first, then move the pointer.
    task automatic set_wptr(input int w);
        for (int k = wabs; k < w; k++) mem[k % DEPTH] = word(k);
        wabs = w;
        rq2_wptr = gray8(w);
    endtask

    task automatic step(input bit use_v, input vec_t v);
        int  occ_m, pend;
        bit  pop_m, rden_m;
        occ_m  = q.size();
        pop_m  = (occ_m > 0) && rif.rready;
        pend   = int'(inflight_m) + occ_m - int'(pop_m);
        rden_m = !empty_m && (pend < 2);
        #1;
        chk("rden", rden, rden_m);
        chk("raddr", raddr, rd_m % DEPTH);
        chk("rptr", rptr, gray8(rd_m));
        chk("rempty", rempty, empty_m);
        chk("rlevel", rlevel, level_m);
        chk("ralmost_empty", ralmost_empty, ae_m);
        chk("rvalid", rif.rvalid, occ_m > 0);
        if (occ_m > 0) chk("rdata", rif.rdata, word(q[0]));
        if (use_v) begin
            chk("tbl_rden", rden, v.rden);
            chk("tbl_raddr", raddr, v.raddr);
            chk("tbl_rvalid", rif.rvalid, v.rvalid);
            chk("tbl_rempty", rempty, v.rempty);
            chk("tbl_rlevel", rlevel, v.rlevel);
            chk("tbl_ae", ralmost_empty, v.ae);
            if (v.didx >= 0) chk("tbl_rdata", rif.rdata, word(v.didx));
        end
        if (rden) begin
            raddr_log.push_back(int'(raddr));
            rden_cnt++;
        end
        if (rif.rvalid && rif.rready) pops++;
        @(posedge rclk);
        if (pop_m) void'(q.pop_front());
        if (inflight_m) q.push_back(infl_idx);
        inflight_m = rden_m;
        infl_idx   = rd_m;
        if (rden_m) rd_m++;
        empty_m = ((rd_m % 256) == (wabs % 256));
        level_m = (wabs - rd_m) % 256;
        ae_m    = (level_m <= 4);
        @(negedge rclk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t nov;
        int   first_lvl;
        int   exp_ra[4];
        nov = '{default: 0};
        rif.rready = 1'b0;
        wabs = 0;
        model_reset();

        // rst wptr rdy | rden raddr rvalid didx rempty rlevel ae
        add(1, 0, 1,  0, 0, 0, -1, 1, 0, 1);
        add(0, 0, 1,  0, 0, 0, -1, 1, 0, 1);
        add(0, 0, 1,  0, 0, 0, -1, 1, 0, 1);
        // single word
        add(0, 1, 1,  0, 0, 0, -1, 1, 0, 1);
        add(0, 1, 1,  1, 0, 0, -1, 0, 1, 1);
        add(0, 1, 1,  0, 1, 0, -1, 1, 0, 1);
        add(0, 1, 1,  0, 1, 1,  0, 1, 0, 1);
        add(0, 1, 1,  0, 1, 0, -1, 1, 0, 1);
        // four-word burst, no bubbles
        add(1, 4, 1,  0, 0, 0, -1, 1, 0, 1);
        add(0, 4, 1,  1, 0, 0, -1, 0, 4, 1);
        add(0, 4, 1,  1, 1, 0, -1, 0, 3, 1);
        add(0, 4, 1,  1, 2, 1,  0, 0, 2, 1);
        add(0, 4, 1,  1, 3, 1,  1, 0, 1, 1);
        add(0, 4, 1,  0, 4, 1,  2, 1, 0, 1);
        add(0, 4, 1,  0, 4, 1,  3, 1, 0, 1);
        add(0, 4, 1,  0, 4, 0, -1, 1, 0, 1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            set_wptr(tbl[i].wptr);
            rif.rready = tbl[i].rdy;
            step(1'b1, tbl[i]);
        end
        chk("single_rptr", rptr, gray8(4));

        // Stall with ten words available, then drain
        do_reset();
        set_wptr(10);
        rden_cnt = 0;
        repeat (8) step(1'b0, nov);
        chk("stall_rden_pulses", rden_cnt, 2);
        chk("stall_rlevel", rlevel, 8);
        chk("stall_ae", ralmost_empty, 1'b0);
        chk("stall_rvalid", rif.rvalid, 1'b1);
        chk("stall_rdata", rif.rdata, word(0));
        rif.rready = 1'b1;
        pops = 0;
        first_lvl = -1;
        for (int c = 0; c < 40 && pops < 10; c++) begin
            step(1'b0, nov);
            if (first_lvl < 0 && ralmost_empty) first_lvl = int'(rlevel);
        end
        chk("drain_count", pops, 10);
        chk("ae_rise_level", first_lvl, 4);

        // Pointer wrap
        do_reset();
        rif.rready = 1'b1;
        for (int c = 0; c < 400 && !(wabs == 254 && rd_m == 254 && q.size() == 0 && !inflight_m); c++) begin
            if (wabs < 254) set_wptr(wabs + 1);
            step(1'b0, nov);
        end
        chk("wrap_pre_rptr", rptr, gray8(254));
        chk("wrap_pre_rempty", rempty, 1'b1);
        raddr_log.delete();
        set_wptr(258);
        step(1'b0, nov);
        chk("wrap_start_level", rlevel, 4);
        repeat (10) step(1'b0, nov);
        exp_ra = '{126, 127, 0, 1};
        chk("wrap_rden_count", raddr_log.size(), 4);
        for (int i = 0; i < 4 && i < raddr_log.size(); i++) chk("wrap_raddr", raddr_log[i], exp_ra[i]);
        chk("wrap_end_rptr", rptr, 8'h03);

        // Asynchronous reset mid-burst: two words buffered, read enable high
        do_reset();
        set_wptr(10);
        repeat (6) step(1'b0, nov);
        rif.rready = 1'b1;
        #1;
        chk("prerst_rden", rden, 1'b1);
        chk("prerst_rvalid", rif.rvalid, 1'b1);
        #1;
        rrst_n = 1'b0;
        #1;
        chk("arst_rptr", rptr, 0);
        chk("arst_rempty", rempty, 1'b1);
        chk("arst_ae", ralmost_empty, 1'b1);
        chk("arst_rlevel", rlevel, 0);
        chk("arst_rvalid", rif.rvalid, 1'b0);
        chk("arst_rdata", rif.rdata, 0);
        chk("arst_rden", rden, 1'b0);
        model_reset();
        wabs = 0;
        rq2_wptr = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
        repeat (5) step(1'b0, nov);
        chk("postrst_rempty", rempty, 1'b1);
        chk("postrst_rvalid", rif.rvalid, 1'b0);

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int wp, rp;
            case ((c / 500) % 4)
                0:       begin wp = 90;  rp = 100; end
                1:       begin wp = 30;  rp = 50;  end
                2:       begin wp = 100; rp = 20;  end
                default: begin wp = 60;  rp = 90;  end
            endcase
            if (wabs < rd_m + DEPTH && $urandom_range(99) < wp) set_wptr(wabs + 1);
            rif.rready = ($urandom_range(99) < rp);
            step(1'b0, nov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
